// File: rtl/adc_sample_writer.sv
// rtl/adc_sample_writer.sv - interleaves EMG/ECG samples into per-channel RAM rings, yielding port B to VGA reads
module adc_sample_writer #(
  parameter int          SAMPLE_INTERVAL = 125000,
  parameter int          DEPTH           = 640,
  parameter logic [11:0] EMG_BASE        = 12'h800,
  parameter logic [11:0] ECG_BASE        = 12'hA80,
  parameter int          MAX_WAIT        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] emg_in,
  input  logic [31:0] ecg_in,
  input  logic        vga_req,
  input  logic [11:0] vga_addr,
  input  logic        ovr_clr,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        vga_gnt,
  output logic [9:0]  emg_wptr,
  output logic [9:0]  ecg_wptr,
  output logic        overrun
);

  localparam int CW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int WW = $clog2(MAX_WAIT + 2);

  typedef enum logic [1:0] {IDLE, PEND, WRITE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            sel_ecg;
  logic            lat_ecg;
  logic [31:0]     hold;
  logic [11:0]     addr_lat;
  logic [WW-1:0]   wait_cnt;

  function automatic logic [9:0] wrap_inc(input logic [9:0] w);
    return (w == 10'(DEPTH - 1)) ? 10'd0 : w + 10'd1;
  endfunction

  assign tick = (tick_cnt == CW'(SAMPLE_INTERVAL - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = PEND;
      // VGA gets priority only until the wait budget is spent
      PEND:    if (!vga_req || wait_cnt == WW'(MAX_WAIT)) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = vga_addr;
    vga_gnt  = vga_req;
    ram_din  = hold;
    if (state == WRITE) begin
      ram_we   = 1'b1;
      ram_addr = addr_lat;
      vga_gnt  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      sel_ecg  <= 1'b0;
      lat_ecg  <= 1'b0;
      hold     <= '0;
      addr_lat <= '0;
      wait_cnt <= '0;
      emg_wptr <= '0;
      ecg_wptr <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      if (tick) sel_ecg <= ~sel_ecg;

      if (tick && state == IDLE) begin
        hold     <= sel_ecg ? ecg_in : emg_in;
        addr_lat <= sel_ecg ? (ECG_BASE + {2'b00, ecg_wptr}) : (EMG_BASE + {2'b00, emg_wptr});
        lat_ecg  <= sel_ecg;
        wait_cnt <= '0;
      end else if (state == PEND && vga_req && wait_cnt != WW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      if (state == WRITE) begin
        if (lat_ecg) ecg_wptr <= wrap_inc(ecg_wptr);
        else         emg_wptr <= wrap_inc(emg_wptr);
      end

      // a tick that finds the writer busy is dropped; setting beats clearing
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_writer.sv
// tb/tb_adc_sample_writer.sv - scoreboard bench for adc_sample_writer
module tb_adc_sample_writer;

  logic        clock;
  logic        reset, reset2;
  logic [31:0] emg_in, ecg_in;
  logic        vga_req, vga_req2;
  logic [11:0] vga_addr;
  logic        ovr_clr, ovr_clr2;
  logic        ram_we, ram_we2;
  logic [11:0] ram_addr, ram_addr2;
  logic [31:0] ram_din, ram_din2;
  logic        vga_gnt, vga_gnt2;
  logic [9:0]  emg_wptr, ecg_wptr, emg_wptr2, ecg_wptr2;
  logic        overrun, overrun2;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t sb[$];
  wr_t exp_wr;

  adc_sample_writer #(
    .SAMPLE_INTERVAL(10), .DEPTH(4), .EMG_BASE(12'h800), .ECG_BASE(12'hA80), .MAX_WAIT(3)
  ) dut (
    .clock(clock), .reset(reset), .emg_in(emg_in), .ecg_in(ecg_in),
    .vga_req(vga_req), .vga_addr(vga_addr), .ovr_clr(ovr_clr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .vga_gnt(vga_gnt),
    .emg_wptr(emg_wptr), .ecg_wptr(ecg_wptr), .overrun(overrun)
  );

  adc_sample_writer #(
    .SAMPLE_INTERVAL(2), .DEPTH(4), .EMG_BASE(12'h800), .ECG_BASE(12'hA80), .MAX_WAIT(3)
  ) dut2 (
    .clock(clock), .reset(reset2), .emg_in(emg_in), .ecg_in(ecg_in),
    .vga_req(vga_req2), .vga_addr(vga_addr), .ovr_clr(ovr_clr2),
    .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2), .vga_gnt(vga_gnt2),
    .emg_wptr(emg_wptr2), .ecg_wptr(ecg_wptr2), .overrun(overrun2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // every write of the main instance must match the head of the scoreboard
  always @(negedge clock) begin
    if (ram_we === 1'b1) begin
      if (sb.size() == 0) begin
        assertions++; failures++;
        $display("FAIL unexpected_write: got write addr %h data %h at cycle %0d, required no write", ram_addr, ram_din, cyc);
      end else begin
        exp_wr = sb.pop_front();
        assertions++;
        if (ram_addr !== exp_wr.addr) begin
          failures++;
          $display("FAIL write_addr: got %h, required %h", ram_addr, exp_wr.addr);
        end
        assertions++;
        if (ram_din !== exp_wr.data) begin
          failures++;
          $display("FAIL write_data: got %h, required %h", ram_din, exp_wr.data);
        end
        assertions++;
        if (cyc !== exp_wr.cyc) begin
          failures++;
          $display("FAIL write_cycle: got %0d, required %0d", cyc, exp_wr.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input int c);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = c;
    sb.push_back(w);
  endtask

  task automatic test_sb_empty(input string name);
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: got %0d outstanding writes, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    vga_req  = 1'b1;
    vga_addr = 12'h3C5;
    @(negedge clock);
    assertions++; if (ram_we !== 1'b0)     begin failures++; $display("FAIL reset_ram_we: got %b, required 0", ram_we); end
    assertions++; if (vga_gnt !== 1'b1)    begin failures++; $display("FAIL reset_vga_gnt: got %b, required 1", vga_gnt); end
    assertions++; if (ram_addr !== 12'h3C5) begin failures++; $display("FAIL reset_ram_addr: got %h, required 3c5", ram_addr); end
    assertions++; if (ram_din !== 32'h0)   begin failures++; $display("FAIL reset_ram_din: got %h, required 0", ram_din); end
    assertions++; if (emg_wptr !== 10'd0)  begin failures++; $display("FAIL reset_emg_wptr: got %0d, required 0", emg_wptr); end
    assertions++; if (ecg_wptr !== 10'd0)  begin failures++; $display("FAIL reset_ecg_wptr: got %0d, required 0", ecg_wptr); end
    assertions++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    assertions++; if (ram_we2 !== 1'b0)    begin failures++; $display("FAIL reset_ram_we2: got %b, required 0", ram_we2); end
    vga_req = 1'b0;
  endtask

  task automatic test_first_write();
    emg_in = 32'h123; ecg_in = 32'h456; vga_req = 1'b0;
    reset_dut();
    push_wr(12'h800, 32'h123, 11);
    while (cyc < 12) begin
      step();
      if (cyc == 10) begin
        assertions++;
        if (ram_we !== 1'b0) begin failures++; $display("FAIL first_early_we: got %b at cycle 10, required 0", ram_we); end
      end
    end
    assertions++; if (emg_wptr !== 10'd1) begin failures++; $display("FAIL first_emg_wptr: got %0d, required 1", emg_wptr); end
    assertions++; if (ecg_wptr !== 10'd0) begin failures++; $display("FAIL first_ecg_wptr: got %0d, required 0", ecg_wptr); end
    test_sb_empty("first_write");
  endtask

  task automatic test_ring_wrap();
    int  m_emg = 0;
    int  m_ecg = 0;
    bit  m_sel = 1'b0;
    vga_req = 1'b0;
    reset_dut();
    emg_in = 32'hE000_0000; ecg_in = 32'hC000_0000;
    while (cyc < 95) begin
      step();
      if (cyc == 85) begin
        assertions++; if (emg_wptr !== 10'd0) begin failures++; $display("FAIL wrap_emg_wptr8: got %0d, required 0", emg_wptr); end
        assertions++; if (ecg_wptr !== 10'd0) begin failures++; $display("FAIL wrap_ecg_wptr8: got %0d, required 0", ecg_wptr); end
      end
      emg_in = 32'hE000_0000 | 32'(cyc);
      ecg_in = 32'hC000_0000 | 32'(cyc);
      if (cyc % 10 == 9) begin
        if (!m_sel) begin
          push_wr(12'h800 + 12'(m_emg), emg_in, cyc + 2);
          m_emg = (m_emg + 1) % 4;
        end else begin
          push_wr(12'hA80 + 12'(m_ecg), ecg_in, cyc + 2);
          m_ecg = (m_ecg + 1) % 4;
        end
        m_sel = ~m_sel;
      end
    end
    assertions++; if (emg_wptr !== 10'd1) begin failures++; $display("FAIL wrap_emg_wptr9: got %0d, required 1", emg_wptr); end
    test_sb_empty("ring_wrap");
  endtask

  task automatic test_vga_hold();
    emg_in = 32'hA5A5_0001; ecg_in = 32'h5A5A_0002;
    vga_req = 1'b1; vga_addr = 12'h100;
    reset_dut();
    push_wr(12'h800, 32'hA5A5_0001, 14);
    while (cyc < 16) begin
      step();
      assertions++;
      if (ram_we !== (cyc == 14)) begin failures++; $display("FAIL hold_we: got %b at cycle %0d", ram_we, cyc); end
      assertions++;
      if (vga_gnt !== (cyc != 14)) begin failures++; $display("FAIL hold_gnt: got %b at cycle %0d", vga_gnt, cyc); end
      if (cyc != 14) begin
        assertions++;
        if (ram_addr !== vga_addr) begin failures++; $display("FAIL hold_addr: got %h, required %h at cycle %0d", ram_addr, vga_addr, cyc); end
      end
      vga_addr = 12'h100 + 12'(cyc);
    end
    assertions++; if (emg_wptr !== 10'd1) begin failures++; $display("FAIL hold_emg_wptr: got %0d, required 1", emg_wptr); end
    test_sb_empty("vga_hold");
    vga_req = 1'b0;
  endtask

  task automatic test_reset_mid_pend();
    emg_in = 32'h0000_0E01; ecg_in = 32'h0000_0C01; vga_req = 1'b0; vga_addr = 12'h2AA;
    reset_dut();
    push_wr(12'h800, 32'h0000_0E01, 11);
    while (cyc < 21) begin
      step();
      if (cyc == 12) vga_req = 1'b1;
    end
    assertions++; if (ram_din !== 32'h0000_0C01) begin failures++; $display("FAIL pend_hold: got %h, required c01", ram_din); end
    reset = 1'b1;
    #1;
    assertions++; if (ram_we !== 1'b0)    begin failures++; $display("FAIL midrst_we: got %b, required 0", ram_we); end
    assertions++; if (ram_din !== 32'h0)  begin failures++; $display("FAIL midrst_din: got %h, required 0", ram_din); end
    assertions++; if (emg_wptr !== 10'd0) begin failures++; $display("FAIL midrst_emg_wptr: got %0d, required 0", emg_wptr); end
    assertions++; if (vga_gnt !== 1'b1)   begin failures++; $display("FAIL midrst_gnt: got %b, required 1", vga_gnt); end
    assertions++; if (ram_addr !== 12'h2AA) begin failures++; $display("FAIL midrst_addr: got %h, required 2aa", ram_addr); end
    @(negedge clock);
    reset = 1'b0; cyc = 0; vga_req = 1'b0;
    push_wr(12'h800, 32'h0000_0E01, 11);
    while (cyc < 12) begin
      step();
      if (cyc == 10) begin
        assertions++;
        if (ram_we !== 1'b0) begin failures++; $display("FAIL midrst_early_we: got %b, required 0", ram_we); end
      end
    end
    test_sb_empty("reset_mid_pend");
    reset = 1'b1;
  endtask

  task automatic test_overrun();
    vga_req2 = 1'b1; ovr_clr2 = 1'b0;
    reset2 = 1'b1;
    @(negedge clock);
    reset2 = 1'b0; cyc = 0;
    while (cyc < 16) begin
      step();
      case (cyc)
        3: begin
          assertions++; if (overrun2 !== 1'b0) begin failures++; $display("FAIL ovr_before: got %b, required 0", overrun2); end
        end
        4: begin
          assertions++; if (overrun2 !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b, required 1", overrun2); end
        end
        6, 12: begin
          assertions++; if (ram_we2 !== 1'b1) begin failures++; $display("FAIL ovr_we: got %b, required 1 at cycle %0d", ram_we2, cyc); end
          assertions++;
          if (ram_addr2 !== ((cyc == 6) ? 12'h800 : 12'hA80)) begin
            failures++; $display("FAIL ovr_addr: got %h at cycle %0d", ram_addr2, cyc);
          end
          assertions++; if (vga_gnt2 !== 1'b0) begin failures++; $display("FAIL ovr_gnt: got %b, required 0", vga_gnt2); end
        end
        7: begin
          assertions++; if (emg_wptr2 !== 10'd1) begin failures++; $display("FAIL ovr_emg_wptr: got %0d, required 1", emg_wptr2); end
          assertions++; if (ecg_wptr2 !== 10'd0) begin failures++; $display("FAIL ovr_ecg_wptr: got %0d, required 0", ecg_wptr2); end
        end
        13: begin
          assertions++; if (overrun2 !== 1'b1)   begin failures++; $display("FAIL ovr_sticky: got %b, required 1", overrun2); end
          assertions++; if (ecg_wptr2 !== 10'd1) begin failures++; $display("FAIL ovr_ecg_wptr2: got %0d, required 1", ecg_wptr2); end
          ovr_clr2 = 1'b1;
        end
        14: begin
          assertions++; if (overrun2 !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b, required 0", overrun2); end
          ovr_clr2 = 1'b0;
        end
        15: begin
          assertions++; if (overrun2 !== 1'b0) begin failures++; $display("FAIL ovr_stays_clear: got %b, required 0", overrun2); end
          ovr_clr2 = 1'b1;
        end
        16: begin
          assertions++; if (overrun2 !== 1'b1) begin failures++; $display("FAIL ovr_set_wins: got %b, required 1", overrun2); end
          ovr_clr2 = 1'b0;
        end
        default: ;
      endcase
    end
    reset2 = 1'b1;
    vga_req2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    emg_in = '0; ecg_in = '0;
    vga_req = 1'b0; vga_req2 = 1'b0; vga_addr = '0;
    ovr_clr = 1'b0; ovr_clr2 = 1'b0;
    test_reset();
    test_first_write();
    test_ring_wrap();
    test_vga_hold();
    test_reset_mid_pend();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/adc_sample_writer.md
ADC_SAMPLE_WRITER -- requirements
Module: adc_sample_writer

Interface
REQ-001 Parameter SAMPLE_INTERVAL, default 125000, clock cycles between consecutive sample ticks.
REQ-002 Parameter DEPTH, default 640, ring-buffer length in words per channel.
REQ-003 Parameter EMG_BASE, default 12'h800, RAM word address of EMG ring entry 0.
REQ-004 Parameter ECG_BASE, default 12'hA80, RAM word address of ECG ring entry 0.
REQ-005 Parameter MAX_WAIT, default 8, cycles a pending write may defer to VGA before forcing.
REQ-006 clock  in  1  system clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 emg_in  in  32  current EMG sample from ADC capture.
REQ-009 ecg_in  in  32  current ECG sample from ADC capture.
REQ-010 vga_req  in  1  VGA requests RAM port B read this cycle.
REQ-011 vga_addr  in  12  VGA read address.
REQ-012 ovr_clr  in  1  clears sticky overrun flag.
REQ-013 ram_we  out  1  RAM port B write enable.
REQ-014 ram_addr  out  12  RAM port B address.
REQ-015 ram_din  out  32  RAM port B write data.
REQ-016 vga_gnt  out  1  VGA read granted this cycle.
REQ-017 emg_wptr  out  10  index of next EMG entry to be written.
REQ-018 ecg_wptr  out  10  index of next ECG entry to be written.
REQ-019 overrun  out  1  sticky: a tick was dropped.

Function
REQ-020 Tick counter SHALL count 0..SAMPLE_INTERVAL-1 and assert one-cycle tick when equal to SAMPLE_INTERVAL-1, then wrap to 0.
REQ-021 Channel select SHALL start at EMG and toggle on every tick; each channel is sampled every 2*SAMPLE_INTERVAL cycles.
REQ-022 On tick in IDLE, block SHALL latch selected channel's input into hold register, latch address base+wptr, and enter PEND next cycle.
REQ-023 States: IDLE, PEND, WRITE; IDLE->PEND on tick; PEND->WRITE when vga_req=0 or wait count reaches MAX_WAIT; WRITE->IDLE unconditionally.
REQ-024 In WRITE, ram_we=1, ram_addr=latched address, ram_din=hold register, vga_gnt=0, for exactly one cycle.
REQ-025 In all other cycles ram_we=0, ram_addr=vga_addr, vga_gnt=vga_req, ram_din=hold register.
REQ-026 Wait counter SHALL clear on entry to PEND and increment each PEND cycle with vga_req=1.
REQ-027 The channel's wptr SHALL increment in the WRITE cycle, wrapping DEPTH-1 -> 0; max address = base+DEPTH-1.
REQ-028 Tick while in PEND or WRITE: sample dropped, channel select still toggles, wptr unchanged, overrun set next cycle.
REQ-029 overrun SHALL remain set until ovr_clr=1; simultaneous set and clear: set wins.
REQ-030 Write latency tick->ram_we SHALL be 2 cycles when vga_req=0, at most MAX_WAIT+2 cycles otherwise.

Reset
REQ-031 Reset asserted SHALL immediately force: state IDLE, tick counter 0, channel EMG, wptrs 0, overrun 0, ram_we 0, hold register 0, wait count 0.
REQ-032 Reset mid-PEND SHALL abandon the pending write; no ram_we pulse after reset deasserts until a new tick.
REQ-033 First tick after reset release SHALL occur SAMPLE_INTERVAL cycles later and sample EMG.

Verification (SAMPLE_INTERVAL=10, DEPTH=4, MAX_WAIT=3)
REQ-034 emg_in=32'h123, vga_req=0, release reset -> cycle 11: ram_we=1, ram_addr=12'h800, ram_din=32'h123; emg_wptr=1 afterwards.
REQ-035 Run 8 ticks, vga_req=0 -> EMG addresses 800,801,802,803 then wrap to 800; ECG 0xA80..0xA83; wptrs return to 0.
REQ-036 vga_req=1 held -> write forced after 3 PEND cycles; vga_gnt=0 only in the WRITE cycle; ram_addr=vga_addr otherwise.
REQ-037 SAMPLE_INTERVAL=2, MAX_WAIT=3, vga_req=1 -> tick during PEND sets overrun; dropped channel's wptr unchanged; ovr_clr=1 clears it.
REQ-038 Assert reset during PEND -> all outputs at reset values within the same cycle; no write occurs afterwards before next tick.
